// File: rtl/alu_issue.sv
// alu_issue: register file, serial issue and writeback stage in front of the 16-bit ALU
module alu_issue #(
  parameter int NREG = 8,
  parameter int DW = 16,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  input  logic          in_setf,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  output logic          alu_enflags,
  input  logic [DW-1:0] alu_s,
  output logic          done,
  output logic [AW-1:0] done_rd,
  output logic [DW-1:0] done_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] alu_a_q, alu_b_q, done_data_q;
  logic [2:0] alu_op_q;
  logic enflags_q;
  logic [AW-1:0] rd_q, done_rd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = IDLE;
    state_d = (state_q == IDLE) ? (in_valid ? EXEC : IDLE) :
              (state_q == EXEC) ? WB : IDLE;
  end
  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
    done = (state_q == WB);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_op_q <= '0;
      enflags_q <= 1'b0;
      rd_q <= '0;
      done_rd_q <= '0;
      done_data_q <= '0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        alu_a_q <= rf_q[in_rs1];
        alu_b_q <= in_use_imm ? in_imm : rf_q[in_rs2];
        alu_op_q <= in_op;
        enflags_q <= in_setf;
        rd_q <= in_rd;
      end
    end else if (state_q == EXEC) begin
      if (rd_q != '0) rf_q[rd_q] <= alu_s;
      done_rd_q <= rd_q;
      done_data_q <= alu_s;
    end else begin
      // flags stay enabled through WB so the ALU's second negedge sees the fresh result
      enflags_q <= 1'b0;
    end
  end
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_op = alu_op_q;
  assign alu_enflags = enflags_q;
  assign done_rd = done_rd_q;
  assign done_data = done_data_q;
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vector table plus streaming and reset-abort sequences for alu_issue
module tb_alu_issue;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_use_imm = 1'b0, in_setf = 1'b0;
  logic [2:0] in_op = '0;
  logic [2:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0, dbg_addr = '0, done_rd;
  logic [15:0] in_imm = '0, alu_a, alu_b, alu_s = '0, done_data, dbg_data;
  logic [2:0] alu_op;
  logic alu_enflags, done;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .in_setf(in_setf), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_enflags(alu_enflags), .alu_s(alu_s), .done(done), .done_rd(done_rd),
    .done_data(done_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU stand-in: evaluates on negedge like the real ALU
  always @(negedge clk)
    case (alu_op)
      3'b000: alu_s <= alu_a + alu_b;
      3'b001: alu_s <= alu_a - alu_b;
      3'b111: alu_s <= alu_a ^ alu_b;
      default: alu_s <= alu_a & alu_b;
    endcase

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op, rd, rs1, rs2;
    logic use_imm;
    logic [15:0] imm;
    logic setf;
    logic [15:0] exp;
  } vec_t;

  vec_t v [7];

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input vec_t x);
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1; in_op = x.op; in_rd = x.rd; in_rs1 = x.rs1; in_rs2 = x.rs2;
    in_use_imm = x.use_imm; in_imm = x.imm; in_setf = x.setf; dbg_addr = x.rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_ready", in_ready, 0);
    chk("exec_enflags", alu_enflags, x.setf);
    chk("exec_op", alu_op, x.op);
    chk("exec_done", done, 0);
    @(posedge clk); #1;
    chk("wb_done", done, 1);
    chk("wb_rd", done_rd, x.rd);
    chk("wb_data", done_data, x.exp);
    chk("wb_reg", dbg_data, (x.rd == 0) ? 16'h0 : x.exp);
    chk("wb_enflags", alu_enflags, x.setf);
    chk("wb_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_enflags", alu_enflags, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    int acc [$];
    bit seen;
    v[0] = '{3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0, 16'h1234};
    v[1] = '{3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF};
    v[2] = '{3'b000, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001, 1'b0, 16'h0001};
    v[3] = '{3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 16'hFFFE};
    v[4] = '{3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0055, 1'b0, 16'h0055};
    v[5] = '{3'b111, 3'd4, 3'd3, 3'd3, 1'b0, 16'hAAAA, 1'b1, 16'h0000};
    v[6] = '{3'b000, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 16'h0000};

    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_enflags", alu_enflags, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_a", alu_a, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      chk("rst_reg", dbg_data, 0);
    end

    for (int i = 0; i < 7; i++) issue(v[i]);
    dbg_addr = 3'd0; #1;
    chk("r0_zero", dbg_data, 0);

    // in_valid held high: accepts must land every third cycle
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b000; in_rd = 3'd7; in_rs1 = 3'd7; in_rs2 = 3'd0;
    in_use_imm = 1'b1; in_imm = 16'h0003; in_setf = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (in_ready) acc.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream_count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("stream_gap1", acc[1] - acc[0], 3);
      chk("stream_gap2", acc[2] - acc[1], 3);
    end
    repeat (3) @(negedge clk);
    dbg_addr = 3'd7; #1;
    chk("stream_r7", dbg_data, 16'h0009);

    // reset during EXEC aborts the writeback
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1; in_op = 3'b000; in_rd = 3'd5; in_rs1 = 3'd0;
    in_use_imm = 1'b1; in_imm = 16'h0007; in_setf = 1'b1; dbg_addr = 3'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_in_exec", in_ready, 0);
    @(negedge clk); rst = 1'b1; #2;
    chk("abort_enflags", alu_enflags, 0);
    rst = 1'b0; #1;
    chk("abort_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_r5", dbg_data, 0);
    dbg_addr = 3'd3; #1;
    chk("abort_r3_cleared", dbg_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
